// File: rtl/hack_core_param.sv
// Parametrised Hack CPU core: A/C instruction execution, wait-stated slow-memory window,
// external stall, self-loop halt detection and a retired-instruction counter.
module hack_core_param #(
  parameter int                WIDTH      = 16,
  parameter logic [WIDTH-1:0]  SLOW_MASK  = WIDTH'(16'hE000),
  parameter logic [WIDTH-1:0]  SLOW_MATCH = WIDTH'(16'h4000),
  parameter int                SLOW_WAIT  = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  instruction,
  input  logic              mem_busy,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              stall_req,
  output logic              mem_load,
  output logic [WIDTH-1:0]  mem_address,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic [WIDTH-1:0]  prog_counter,
  output logic              halted,
  output logic [31:0]       retired
);

  typedef enum logic [2:0] {
    FETCH, DECODE, MEM_READ, MEM_FETCH, WRITE_BACK, HALT
  } state_t;

  localparam logic [2:0] WAIT_LAST = 3'(SLOW_WAIT - 1);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   a_reg, a_next;
  logic [WIDTH-1:0]   d_reg, d_next;
  logic [WIDTH-1:0]   pc_reg, pc_next;
  logic [WIDTH-1:0]   x_reg, x_next;
  logic [WIDTH-1:0]   y_reg, y_next;
  logic [WIDTH-1:0]   instr_addr_reg, instr_addr_next;
  logic [WIDTH-1:0]   last_a_addr_reg, last_a_addr_next;
  logic               last_a_reg, last_a_next;
  logic [5:0]         comp_reg, comp_next;
  logic [2:0]         dest_reg, dest_next;
  logic [2:0]         jmp_reg, jmp_next;
  logic [31:0]        retired_reg, retired_next;
  logic               halted_reg, halted_next;
  logic [2:0]         wait_cnt_reg, wait_cnt_next;
  logic               counting_reg, counting_next;

  logic [WIDTH-1:0]   x_z, x_n, y_z, y_n, alu_raw, alu_out;
  logic               zr, ng, jump, slow, wb_done, halt_hit;

  // Hack ALU on the latched operands and control bits (zx nx zy ny f no).
  always_comb begin
    x_z     = comp_reg[5] ? '0 : x_reg;
    x_n     = comp_reg[4] ? ~x_z : x_z;
    y_z     = comp_reg[3] ? '0 : y_reg;
    y_n     = comp_reg[2] ? ~y_z : y_z;
    alu_raw = comp_reg[1] ? (x_n + y_n) : (x_n & y_n);
    alu_out = comp_reg[0] ? ~alu_raw : alu_raw;
  end

  assign zr   = (alu_out == '0);
  assign ng   = alu_out[WIDTH-1];
  assign jump = (jmp_reg[2] & ng) | (jmp_reg[1] & zr) | (jmp_reg[0] & ~ng & ~zr);
  assign slow = ((a_reg & SLOW_MASK) == SLOW_MATCH);
  assign wb_done = ~dest_reg[0] | ~slow | ~mem_busy;

  // Self-loop, or the "@L / 0;JMP" pair where the jump lands on its own A-instruction.
  assign halt_hit = (a_reg == instr_addr_reg) ||
                    (last_a_reg && (a_reg == instr_addr_reg - WIDTH'(1)) &&
                     (last_a_addr_reg == a_reg));

  always_comb begin
    state_next       = state_reg;
    a_next           = a_reg;
    d_next           = d_reg;
    pc_next          = pc_reg;
    x_next           = x_reg;
    y_next           = y_reg;
    instr_addr_next  = instr_addr_reg;
    last_a_addr_next = last_a_addr_reg;
    last_a_next      = last_a_reg;
    comp_next        = comp_reg;
    dest_next        = dest_reg;
    jmp_next         = jmp_reg;
    retired_next     = retired_reg;
    halted_next      = halted_reg;
    wait_cnt_next    = wait_cnt_reg;
    counting_next    = counting_reg;
    mem_load         = 1'b0;
    case (state_reg)
      FETCH: begin
        if (!stall_req) state_next = DECODE;
      end
      DECODE: begin
        if (!stall_req) begin
          pc_next         = pc_reg + WIDTH'(1);
          instr_addr_next = pc_reg;
          if (!instruction[WIDTH-1]) begin
            a_next           = instruction;
            retired_next     = retired_reg + 32'd1;
            last_a_next      = 1'b1;
            last_a_addr_next = pc_reg;
          end else begin
            comp_next = instruction[11:6];
            dest_next = instruction[5:3];
            jmp_next  = instruction[2:0];
            x_next    = d_reg;
            if (instruction[12]) begin
              state_next = MEM_READ;
            end else begin
              y_next     = a_reg;
              state_next = WRITE_BACK;
            end
          end
        end
      end
      MEM_READ: begin
        // Once the window is seen free the count runs to the end regardless of mem_busy.
        if (!slow) begin
          state_next = MEM_FETCH;
        end else if (counting_reg) begin
          if (wait_cnt_reg == WAIT_LAST) state_next = MEM_FETCH;
          else                           wait_cnt_next = wait_cnt_reg + 3'd1;
        end else if (!mem_busy) begin
          counting_next = 1'b1;
          if (SLOW_WAIT == 0) state_next = MEM_FETCH;
        end
      end
      MEM_FETCH: begin
        y_next        = mem_rdata;
        wait_cnt_next = 3'd0;
        counting_next = 1'b0;
        state_next    = WRITE_BACK;
      end
      WRITE_BACK: begin
        if (wb_done) begin
          mem_load     = dest_reg[0];
          if (dest_reg[2]) a_next = alu_out;
          if (dest_reg[1]) d_next = alu_out;
          retired_next = retired_reg + 32'd1;
          last_a_next  = 1'b0;
          if (jump) begin
            pc_next = a_reg;
            if (halt_hit) begin
              halted_next = 1'b1;
              state_next  = HALT;
            end else begin
              state_next = FETCH;
            end
          end else begin
            state_next = DECODE;
          end
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: state_next = FETCH;
    endcase
    if (!reset_n) mem_load = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg       <= FETCH;
      a_reg           <= '0;
      d_reg           <= '0;
      pc_reg          <= '0;
      x_reg           <= '0;
      y_reg           <= '0;
      instr_addr_reg  <= '0;
      last_a_addr_reg <= '0;
      last_a_reg      <= 1'b0;
      comp_reg        <= '0;
      dest_reg        <= '0;
      jmp_reg         <= '0;
      retired_reg     <= '0;
      halted_reg      <= 1'b0;
      wait_cnt_reg    <= '0;
      counting_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      a_reg           <= a_next;
      d_reg           <= d_next;
      pc_reg          <= pc_next;
      x_reg           <= x_next;
      y_reg           <= y_next;
      instr_addr_reg  <= instr_addr_next;
      last_a_addr_reg <= last_a_addr_next;
      last_a_reg      <= last_a_next;
      comp_reg        <= comp_next;
      dest_reg        <= dest_next;
      jmp_reg         <= jmp_next;
      retired_reg     <= retired_next;
      halted_reg      <= halted_next;
      wait_cnt_reg    <= wait_cnt_next;
      counting_reg    <= counting_next;
    end
  end

  assign mem_address  = a_reg;
  assign mem_wdata    = alu_out;
  assign prog_counter = pc_reg;
  assign halted       = halted_reg;
  assign retired      = retired_reg;

endmodule

// File: tb/tb_hack_core_param.sv
// Directed bench for hack_core_param: combinational ROM model, write scoreboard,
// cycle-exact checks of slow-window timing, halt, stall and reset behaviour.
module tb_hack_core_param;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  instruction;
  logic          mem_busy;
  logic [W-1:0]  mem_rdata;
  logic          stall_req;
  logic          mem_load;
  logic [W-1:0]  mem_address;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  prog_counter;
  logic          halted;
  logic [31:0]   retired;

  logic [W-1:0]  rom [0:255];
  logic [31:0]   exp_q [$];
  int            tests_run = 0;
  int            tests_failed = 0;

  hack_core_param #(.WIDTH(W), .SLOW_MASK(16'hE000), .SLOW_MATCH(16'h4000), .SLOW_WAIT(2)) dut (
    .clk(clk), .reset_n(reset_n), .instruction(instruction), .mem_busy(mem_busy),
    .mem_rdata(mem_rdata), .stall_req(stall_req), .mem_load(mem_load),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .prog_counter(prog_counter),
    .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;
  assign instruction = rom[prog_counter[7:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Samples the write strobe mid-cycle against the scoreboard, then advances one edge.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    if (mem_load === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(mem_load), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("write_addr_data", {mem_address, mem_wdata}, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  task automatic do_reset(input logic busy);
    reset_n   = 1'b0;
    stall_req = 1'b0;
    exp_q.delete();
    tick();
    tick();
    check("rst_pc", 32'(prog_counter), 32'd0);
    check("rst_a", 32'(mem_address), 32'd0);
    check("rst_d", 32'(dut.d_reg), 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_mem_load", 32'(mem_load), 32'd0);
    mem_busy = busy;
    reset_n  = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    stall_req = 1'b0;
    mem_busy  = 1'b0;
    mem_rdata = 16'h1234;

    // 1) @5 ; D=A ; then @2 / 0;JMP halt idiom
    rom_clear();
    rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0002; rom[3] = 16'hEA87;
    do_reset(1'b0);
    tick(); tick();
    check("t1_pc_after_a", 32'(prog_counter), 32'd1);
    check("t1_retired_after_a", retired, 32'd1);
    check("t1_a", 32'(mem_address), 32'd5);
    tick(); tick();
    check("t1_d", 32'(dut.d_reg), 32'd5);
    check("t1_a_kept", 32'(mem_address), 32'd5);
    check("t1_pc", 32'(prog_counter), 32'd2);
    check("t1_retired", retired, 32'd2);
    repeat (6) tick();
    check("t1_halted", 32'(halted), 32'd1);
    check("t1_halt_pc", 32'(prog_counter), 32'd2);
    check("t1_halt_retired", retired, 32'd4);

    // 2) @0x4000 ; D=M with 3 busy cycles and SLOW_WAIT=2
    rom_clear();
    rom[0] = 16'h4000; rom[1] = 16'hFC10; rom[2] = 16'h0002; rom[3] = 16'hEA87;
    do_reset(1'b1);
    repeat (3) tick();
    check("t2_addr_slow", 32'(mem_address), 32'h4000);
    repeat (3) tick();
    mem_busy = 1'b0;
    tick();
    mem_busy = 1'b1;
    repeat (3) tick();
    check("t2_d_not_yet", 32'(dut.d_reg), 32'd0);
    tick();
    check("t2_d_loaded", 32'(dut.d_reg), 32'h1234);
    check("t2_retired", retired, 32'd2);
    repeat (4) tick();
    check("t2_halted", 32'(halted), 32'd1);
    check("t2_halt_retired", retired, 32'd4);

    // 3) M=D to slow window held by busy, then to fast address while busy
    rom_clear();
    rom[0] = 16'h0007; rom[1] = 16'hEC10; rom[2] = 16'h4000; rom[3] = 16'hE308;
    rom[4] = 16'h0010; rom[5] = 16'hE308; rom[6] = 16'h0006; rom[7] = 16'hEA87;
    do_reset(1'b1);
    repeat (4) tick();
    check("t3_d", 32'(dut.d_reg), 32'd7);
    repeat (6) tick();
    check("t3_no_load_busy", 32'(mem_load), 32'd0);
    check("t3_retired_blocked", retired, 32'd3);
    mem_busy = 1'b0;
    exp_q.push_back({16'h4000, 16'h0007});
    tick();
    check("t3_slow_pulse_seen", 32'(exp_q.size()), 32'd0);
    mem_busy = 1'b1;
    repeat (2) tick();
    exp_q.push_back({16'h0010, 16'h0007});
    tick();
    check("t3_fast_pulse_seen", 32'(exp_q.size()), 32'd0);
    repeat (3) tick();
    check("t3_halted", 32'(halted), 32'd1);
    check("t3_halt_pc", 32'(prog_counter), 32'd6);
    check("t3_halt_retired", retired, 32'd8);
    repeat (3) tick();

    // 4) jump to 4, then @4 / 0;JMP at address 5 halts
    rom_clear();
    rom[0] = 16'h0004; rom[1] = 16'hEA87; rom[4] = 16'h0004; rom[5] = 16'hEA87;
    do_reset(1'b0);
    repeat (4) tick();
    check("t4_jump_pc", 32'(prog_counter), 32'd4);
    check("t4_not_halted", 32'(halted), 32'd0);
    check("t4_retired_jump", retired, 32'd2);
    repeat (3) tick();
    check("t4_halted_late", 32'(halted), 32'd0);
    tick();
    check("t4_halted", 32'(halted), 32'd1);
    check("t4_halt_pc", 32'(prog_counter), 32'd4);
    check("t4_halt_retired", retired, 32'd4);
    repeat (5) tick();
    check("t4_frozen_pc", 32'(prog_counter), 32'd4);
    check("t4_frozen_retired", retired, 32'd4);
    check("t4_frozen_load", 32'(mem_load), 32'd0);

    // 5) stall in DECODE and FETCH; self-loop jump halts
    rom_clear();
    rom[0] = 16'h0003; rom[1] = 16'hEC10; rom[2] = 16'hEA87; rom[3] = 16'hEA87;
    do_reset(1'b0);
    tick();
    stall_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_stall_pc", 32'(prog_counter), 32'd0);
      check("t5_stall_retired", retired, 32'd0);
    end
    check("t5_stall_a", 32'(mem_address), 32'd0);
    check("t5_stall_d", 32'(dut.d_reg), 32'd0);
    stall_req = 1'b0;
    tick();
    check("t5_resume_a", 32'(mem_address), 32'd3);
    check("t5_resume_pc", 32'(prog_counter), 32'd1);
    check("t5_resume_retired", retired, 32'd1);
    repeat (4) tick();
    check("t5_jump_pc", 32'(prog_counter), 32'd3);
    check("t5_jump_not_halted", 32'(halted), 32'd0);
    check("t5_jump_retired", retired, 32'd3);
    stall_req = 1'b1;
    repeat (3) tick();
    check("t5_fetch_stall_pc", 32'(prog_counter), 32'd3);
    check("t5_fetch_stall_retired", retired, 32'd3);
    stall_req = 1'b0;
    repeat (3) tick();
    check("t5_self_loop_halted", 32'(halted), 32'd1);
    check("t5_self_loop_pc", 32'(prog_counter), 32'd3);
    check("t5_self_loop_retired", retired, 32'd4);

    // 6) reset during a slow MEM_READ blocked by busy
    rom_clear();
    rom[0] = 16'h4000; rom[1] = 16'hFC10;
    do_reset(1'b1);
    repeat (4) tick();
    check("t6_pre_a", 32'(mem_address), 32'h4000);
    check("t6_pre_retired", retired, 32'd1);
    reset_n = 1'b0;
    tick();
    check("t6_pc", 32'(prog_counter), 32'd0);
    check("t6_a", 32'(mem_address), 32'd0);
    check("t6_d", 32'(dut.d_reg), 32'd0);
    check("t6_retired", retired, 32'd0);
    check("t6_mem_load", 32'(mem_load), 32'd0);
    reset_n  = 1'b1;
    mem_busy = 1'b0;
    tick();
    check("t6_fetch_retired", retired, 32'd0);
    check("t6_fetch_pc", 32'(prog_counter), 32'd0);
    tick();
    check("t6_exec_retired", retired, 32'd1);
    check("t6_exec_a", 32'(mem_address), 32'h4000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
